// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_pkg
// Brief    : Shared widths, LIF constants and sweep FSM encoding for the
//            neuron update pipeline.
// Revision : 1.0
// ============================================================================
package snn_pkg;

  localparam int NUM_NEURONS_DEF   = 10000;
  localparam int ADDR_WIDTH_DEF    = 14;
  localparam int VMEM_WIDTH_DEF    = 16;
  localparam int REF_CTR_WIDTH_DEF = 4;

  localparam logic signed [15:0] V_THRESH_DEF = 16'sd4096;
  localparam logic signed [15:0] V_RESET_DEF  = 16'sd0;
  localparam int                 LEAK_SHIFT_DEF = 4;
  localparam int                 REF_PERIOD_DEF = 4;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/lif_core.sv
`default_nettype none
// ============================================================================
// Module   : lif_core
// Brief    : Combinational leaky integrate-and-fire update for one neuron.
// Revision : 1.0
// ============================================================================
module lif_core
  import snn_pkg::*;
#(
  parameter int                             VMEM_WIDTH    = VMEM_WIDTH_DEF,
  parameter int                             REF_CTR_WIDTH = REF_CTR_WIDTH_DEF,
  parameter logic signed [VMEM_WIDTH-1:0]   V_THRESH      = V_THRESH_DEF,
  parameter logic signed [VMEM_WIDTH-1:0]   V_RESET       = V_RESET_DEF,
  parameter int                             LEAK_SHIFT    = LEAK_SHIFT_DEF,
  parameter int                             REF_PERIOD    = REF_PERIOD_DEF
) (
  input  logic signed [VMEM_WIDTH-1:0]    v,
  input  logic        [REF_CTR_WIDTH-1:0] ref_ctr,
  input  logic signed [VMEM_WIDTH-1:0]    syn_cur,
  output logic signed [VMEM_WIDTH-1:0]    v_next,
  output logic        [REF_CTR_WIDTH-1:0] ref_ctr_next,
  output logic                            spike
);

  localparam logic signed [VMEM_WIDTH-1:0] V_MAX = {1'b0, {(VMEM_WIDTH-1){1'b1}}};
  localparam logic signed [VMEM_WIDTH-1:0] V_MIN = {1'b1, {(VMEM_WIDTH-1){1'b0}}};
  localparam logic [REF_CTR_WIDTH-1:0]     REF_LOAD = REF_CTR_WIDTH'(REF_PERIOD);
  localparam logic [REF_CTR_WIDTH-1:0]     REF_ONE  = REF_CTR_WIDTH'(1);
  localparam logic [REF_CTR_WIDTH-1:0]     REF_ZERO = '0;

  logic signed [VMEM_WIDTH-1:0] v_leak;
  logic signed [VMEM_WIDTH:0]   v_sum;
  logic signed [VMEM_WIDTH-1:0] v_sat;

  // Leak never overflows: subtracting a same-sign fraction only shrinks |v|.
  assign v_leak = v - (v >>> LEAK_SHIFT);
  assign v_sum  = {v_leak[VMEM_WIDTH-1], v_leak} + {syn_cur[VMEM_WIDTH-1], syn_cur};

  // Clamp the one-bit-wider sum back into the signed Vmem range
  always_comb begin
    v_sat = v_sum[VMEM_WIDTH-1:0];
    case (v_sum[VMEM_WIDTH:VMEM_WIDTH-1])
      2'b01:   v_sat = V_MAX;
      2'b10:   v_sat = V_MIN;
      default: v_sat = v_sum[VMEM_WIDTH-1:0];
    endcase
  end

  // Refractory neurons are held at reset; others integrate and may fire
  always_comb begin
    v_next       = v_sat;
    ref_ctr_next = REF_ZERO;
    spike        = 1'b0;
    if (ref_ctr != REF_ZERO) begin
      v_next       = V_RESET;
      ref_ctr_next = ref_ctr - REF_ONE;
    end else if (v_sat >= V_THRESH) begin
      v_next       = V_RESET;
      ref_ctr_next = REF_LOAD;
      spike        = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_update_pipe.sv
`default_nettype none
// ============================================================================
// Module   : neuron_update_pipe
// Brief    : Sweeps all neurons once per time step: reads state and synaptic
//            current, applies the LIF update and writes results back.
// Revision : 1.0
// ============================================================================
module neuron_update_pipe
  import snn_pkg::*;
#(
  parameter int                           NUM_NEURONS   = NUM_NEURONS_DEF,
  parameter int                           ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int                           VMEM_WIDTH    = VMEM_WIDTH_DEF,
  parameter int                           REF_CTR_WIDTH = REF_CTR_WIDTH_DEF,
  parameter logic signed [VMEM_WIDTH-1:0] V_THRESH      = V_THRESH_DEF,
  parameter logic signed [VMEM_WIDTH-1:0] V_RESET       = V_RESET_DEF,
  parameter int                           LEAK_SHIFT    = LEAK_SHIFT_DEF,
  parameter int                           REF_PERIOD    = REF_PERIOD_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,
  output logic        [ADDR_WIDTH-1:0]    o_rd_addr,
  input  logic signed [VMEM_WIDTH-1:0]    i_vmem,
  input  logic        [REF_CTR_WIDTH-1:0] i_ref_ctr,
  input  logic signed [VMEM_WIDTH-1:0]    i_syn_cur,
  output logic                            o_wr_en,
  output logic        [ADDR_WIDTH-1:0]    o_wr_addr,
  output logic signed [VMEM_WIDTH-1:0]    o_vmem,
  output logic        [REF_CTR_WIDTH-1:0] o_ref_ctr,
  output logic                            o_spike_valid,
  output logic        [ADDR_WIDTH-1:0]    o_spike_addr,
  output logic        [ADDR_WIDTH:0]      o_spike_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NEURONS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  sweep_state_t                   state;
  logic                           d1_valid;
  logic                           d2_valid;
  logic        [ADDR_WIDTH-1:0]   d1_addr;
  logic        [ADDR_WIDTH-1:0]   d2_addr;
  logic signed [VMEM_WIDTH-1:0]   lif_v;
  logic        [REF_CTR_WIDTH-1:0] lif_ref;
  logic                           lif_spike;
  logic                           start_ok;
  logic                           fire;

  assign start_ok = (state == ST_IDLE) && i_start;
  assign fire     = d2_valid && lif_spike;

  lif_core #(
    .VMEM_WIDTH    (VMEM_WIDTH),
    .REF_CTR_WIDTH (REF_CTR_WIDTH),
    .V_THRESH      (V_THRESH),
    .V_RESET       (V_RESET),
    .LEAK_SHIFT    (LEAK_SHIFT),
    .REF_PERIOD    (REF_PERIOD)
  ) u_lif_core (
    .v            (i_vmem),
    .ref_ctr      (i_ref_ctr),
    .syn_cur      (i_syn_cur),
    .v_next       (lif_v),
    .ref_ctr_next (lif_ref),
    .spike        (lif_spike)
  );

  // Sweep FSM: issues one read address per cycle, then waits for the last write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      o_rd_addr <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state     <= ST_SWEEP;
            o_rd_addr <= '0;
            o_busy    <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (o_rd_addr == LAST_ADDR) begin
            state     <= ST_DRAIN;
            o_rd_addr <= '0;
          end else begin
            o_rd_addr <= o_rd_addr + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          if (o_wr_en && (o_wr_addr == LAST_ADDR)) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          o_rd_addr <= '0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage delay aligns addresses with memory read data; results are registered out
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_valid      <= 1'b0;
      d1_addr       <= '0;
      d2_valid      <= 1'b0;
      d2_addr       <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_vmem        <= '0;
      o_ref_ctr     <= '0;
      o_spike_valid <= 1'b0;
      o_spike_addr  <= '0;
      o_spike_cnt   <= '0;
    end else begin
      d1_valid      <= (state == ST_SWEEP);
      d1_addr       <= o_rd_addr;
      d2_valid      <= d1_valid;
      d2_addr       <= d1_addr;
      o_wr_en       <= d2_valid;
      o_wr_addr     <= d2_valid ? d2_addr : '0;
      o_vmem        <= d2_valid ? lif_v : '0;
      o_ref_ctr     <= d2_valid ? lif_ref : '0;
      o_spike_valid <= fire;
      o_spike_addr  <= fire ? d2_addr : '0;
      if (start_ok) begin
        o_spike_cnt <= '0;
      end else if (fire) begin
        o_spike_cnt <= o_spike_cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire
